// File: rtl/types_pkg.sv
// Shared core types: sign-extender select, controller state/opcode/PC-source/error encodings
// and the opcode decode record handed from opcode_decode to the controller.
package types_pkg;

    typedef enum logic [1:0] {
        SEL_NONE      = 2'd0,
        SEL_FOURBIT   = 2'd1,
        SEL_EIGHTBIT  = 2'd2,
        SEL_TWELVEBIT = 2'd3
    } sel_t;

    typedef logic [2:0] ctrl_state_t;
    localparam ctrl_state_t ST_IDLE   = 3'd0;
    localparam ctrl_state_t ST_FETCH  = 3'd1;
    localparam ctrl_state_t ST_DECODE = 3'd2;
    localparam ctrl_state_t ST_EXEC   = 3'd3;
    localparam ctrl_state_t ST_MEM    = 3'd4;
    localparam ctrl_state_t ST_WB     = 3'd5;
    localparam ctrl_state_t ST_HALT   = 3'd6;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'h0,
        OP_ADDI  = 4'h1,
        OP_LW    = 4'h2,
        OP_SW    = 4'h3,
        OP_BEQ   = 4'h4,
        OP_JMP   = 4'h5,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_ILLEGAL = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    typedef struct packed {
        sel_t sel;
        logic is_mem;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic uses_imm;
        logic writes_rf;
        logic illegal;
    } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory strobe bundle; master is the controller, slave the datapath side.
interface multicycle_ctrl_if;
   import types_pkg::*;

   logic        start;
   logic [15:0] instr;
   logic        mem_ack;
   logic        alu_zero;
   logic        ir_we;
   logic        pc_we;
   pc_src_t     pc_src;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        rf_we;
   logic        wb_sel;
   logic        alu_src_imm;
   sel_t        offset_sel;
   logic        busy;
   logic        halted;
   err_t        error;

   modport master (
      input  start, instr, mem_ack, alu_zero,
      output ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
             alu_src_imm, offset_sel, busy, halted, error
   );

   modport slave (
      output start, instr, mem_ack, alu_zero,
      input  ir_we, pc_we, pc_src, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel,
             alu_src_imm, offset_sel, busy, halted, error
   );

endinterface

// File: rtl/opcode_decode.sv
// Opcode to control-class decode; purely combinational, zero latency, no backpressure.
module opcode_decode
   import types_pkg::*;
(
   input  opcode_t opcode,
   output dec_t    dec
);

   always_comb begin
      dec = '0;
      case (opcode)
         OP_RTYPE: dec.writes_rf = 1'b1;
         OP_ADDI: begin
            dec.sel       = SEL_FOURBIT;
            dec.uses_imm  = 1'b1;
            dec.writes_rf = 1'b1;
         end
         OP_LW: begin
            dec.sel       = SEL_FOURBIT;
            dec.is_mem    = 1'b1;
            dec.uses_imm  = 1'b1;
            dec.writes_rf = 1'b1;
         end
         OP_SW: begin
            dec.sel      = SEL_FOURBIT;
            dec.is_mem   = 1'b1;
            dec.is_store = 1'b1;
            dec.uses_imm = 1'b1;
         end
         OP_BEQ: begin
            dec.sel       = SEL_EIGHTBIT;
            dec.is_branch = 1'b1;
         end
         OP_JMP: begin
            dec.sel     = SEL_TWELVEBIT;
            dec.is_jump = 1'b1;
         end
         OP_HALT: dec.sel = SEL_NONE;
         default: dec.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller; 3-5 cycles per instruction plus one per memory
// wait cycle; stalls on mem_ack and bus-errors to HALT after MEM_TIMEOUT unacknowledged cycles.
module multicycle_ctrl
   import types_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   multicycle_ctrl_if.master bus
);

   localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

   ctrl_state_t state, state_nxt;
   err_t        err_q, err_nxt;
   sel_t        sel_q;
   logic [7:0]  to_cnt;
   opcode_t     opcode;
   dec_t        dec;
   logic        timeout_hit;

   logic        ir_we, pc_we, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel, alu_src_imm;
   pc_src_t     pc_src;

   // instr[11:0] feeds the sign extender directly; only the opcode matters here
   logic unused_instr_bits;
   assign unused_instr_bits = ^bus.instr[11:0];

   assign opcode = opcode_t'(bus.instr[15:12]);

   opcode_decode u_opcode_decode (
      .opcode (opcode),
      .dec    (dec)
   );

   assign timeout_hit = mem_req && !bus.mem_ack && (to_cnt == TO_LAST);

   always_comb begin
      state_nxt    = state;
      err_nxt      = err_q;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = PC_INC;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      rf_we        = 1'b0;
      wb_sel       = 1'b0;
      alu_src_imm  = 1'b0;
      case (state)
         ST_IDLE: if (bus.start) state_nxt = ST_FETCH;
         ST_FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ack) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               state_nxt = ST_DECODE;
            end else if (timeout_hit) begin
               state_nxt = ST_HALT;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (dec.illegal) begin
               state_nxt = ST_HALT;
               err_nxt   = ERR_ILLEGAL;
            end else if (opcode == OP_HALT) begin
               state_nxt = ST_HALT;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_src_imm = dec.uses_imm;
            if (dec.is_branch) begin
               pc_we     = bus.alu_zero;
               pc_src    = PC_BRANCH;
               state_nxt = ST_FETCH;
            end else if (dec.is_jump) begin
               pc_we     = 1'b1;
               pc_src    = PC_JUMP;
               state_nxt = ST_FETCH;
            end else if (dec.is_mem) begin
               state_nxt = ST_MEM;
            end else begin
               state_nxt = ST_WB;
            end
         end
         ST_MEM: begin
            mem_req      = 1'b1;
            mem_addr_sel = 1'b1;
            alu_src_imm  = 1'b1;
            mem_we       = dec.is_store;
            if (bus.mem_ack) begin
               state_nxt = dec.is_store ? ST_FETCH : ST_WB;
            end else if (timeout_hit) begin
               state_nxt = ST_HALT;
               err_nxt   = ERR_TIMEOUT;
            end
         end
         ST_WB: begin
            rf_we     = dec.writes_rf;
            wb_sel    = dec.is_mem;
            state_nxt = ST_FETCH;
         end
         ST_HALT: state_nxt = ST_HALT;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // The counter is zero whenever no request is pending, so it starts at 0 on entry to FETCH/MEM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         err_q  <= ERR_NONE;
         sel_q  <= SEL_NONE;
         to_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         err_q <= err_nxt;
         if (state == ST_DECODE) sel_q <= dec.sel;
         if (mem_req && !bus.mem_ack) to_cnt <= to_cnt + 8'd1;
         else                         to_cnt <= 8'd0;
      end
   end

   assign bus.ir_we        = ir_we;
   assign bus.pc_we        = pc_we;
   assign bus.pc_src       = pc_src;
   assign bus.mem_req      = mem_req;
   assign bus.mem_we       = mem_we;
   assign bus.mem_addr_sel = mem_addr_sel;
   assign bus.rf_we        = rf_we;
   assign bus.wb_sel       = wb_sel;
   assign bus.alu_src_imm  = alu_src_imm;
   assign bus.offset_sel   = sel_q;
   assign bus.busy         = (state != ST_IDLE) && (state != ST_HALT);
   assign bus.halted       = (state == ST_HALT);
   assign bus.error        = err_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the 16-bit core.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives the offset_sel input of the sign extender; the sign extender's input_value is wired to the IR's instr[11:0].
- Also drives the PC, IR, register file, ALU source and memory handshake strobes, and reports halt and error status.

Parameters:
- MEM_TIMEOUT, 16, maximum cycles mem_req may stay high without mem_ack before a bus error; legal range 2..255.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  leave IDLE and begin fetching
- instr  in  16  current IR contents; opcode is instr[15:12]
- mem_ack  in  1  memory completes the current request this cycle
- alu_zero  in  1  ALU result is zero (BEQ compare)
- ir_we  out  1  load IR
- pc_we  out  1  load PC
- pc_src  out  2  PC source: 0 INC (PC+2), 1 BRANCH (PC+se_value), 2 JUMP (se_value)
- mem_req  out  1  memory request
- mem_we  out  1  write request; valid only with mem_req
- mem_addr_sel  out  1  address source: 0 PC, 1 ALU result
- rf_we  out  1  register file write
- wb_sel  out  1  writeback source: 0 ALU, 1 memory data
- alu_src_imm  out  1  ALU operand B is se_value
- offset_sel  out  sel_t  sign-extender width select
- busy  out  1  state is not IDLE and not HALT
- halted  out  1  state is HALT
- error  out  2  error code: 0 NONE, 1 ILLEGAL, 2 TIMEOUT

Behaviour:

Reset and encoding:
- Asynchronous reset forces state to IDLE, timeout counter to 0, offset_sel to NONE and error to NONE.
- All strobes are Moore/ack-gated combinational decodes of state, so every strobe is 0 immediately on reset, including mid-MEM.

Opcode map:
- 0 R-type: NONE
- 1 ADDI: FOURBIT
- 2 LW: FOURBIT
- 3 SW: FOURBIT
- 4 BEQ: EIGHTBIT
- 5 JMP: TWELVEBIT
- F HALT: NONE
- 6..E: illegal

States and transitions:
- IDLE: all strobes 0. start=1 -> FETCH. start is ignored in every other state.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - On mem_ack: ir_we=1, pc_we=1, pc_src=INC in the same cycle, then -> DECODE.
- DECODE:
  - One cycle; offset_sel register loads the opcode's width at the clock edge leaving DECODE.
  - Illegal opcode -> HALT with error=ILLEGAL.
  - HALT opcode -> HALT with error unchanged (NONE).
  - Otherwise -> EXEC.
- EXEC:
  - alu_src_imm=1 for ADDI/LW/SW; 0 for R-type/BEQ.
  - R-type, ADDI -> WB.
  - LW, SW -> MEM.
  - BEQ: pc_we=alu_zero, pc_src=BRANCH, then -> FETCH.
  - JMP: pc_we=1, pc_src=JUMP, then -> FETCH.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_src_imm=1; mem_we=1 for SW.
  - On mem_ack: LW -> WB, SW -> FETCH.
- WB: rf_we=1; wb_sel=1 for LW, else 0; then -> FETCH.
- HALT: halted=1, all strobes 0; exits only via reset.

offset_sel:
- Holds from EXEC until the next DECODE, so it is stable through BEQ and JMP PC updates.

Timeout:
- Counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 without mem_ack.
- When it reaches MEM_TIMEOUT-1 with no ack -> HALT, error=TIMEOUT.
- An ack in that same cycle wins: normal transition, no error.

Latency (mem_ack in the same cycle as mem_req):
- R-type/ADDI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BEQ/JMP: 3 cycles.
- Each memory wait cycle adds 1.

Decomposition:
- types_pkg additions: ctrl_state_t (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT), opcode_t, pc_src_t, err_t.
- sel_t already lives in types_pkg and is reused.
- One combinational sub-module, opcode_decode: maps opcode_t to {sel_t, is_mem, is_store, is_branch, is_jump, uses_imm, writes_rf, illegal}.

Test Plan:
- Reset, then start=1, instr=16'h1A37 (ADDI), mem_ack tied 1 -> FETCH, DECODE, EXEC, WB on consecutive cycles; offset_sel=FOURBIT from EXEC; alu_src_imm=1 in EXEC; rf_we=1 in WB only.
- instr=16'h4080 (BEQ), alu_zero=1 -> offset_sel=EIGHTBIT, and pc_we=1 with pc_src=BRANCH in EXEC; repeat with alu_zero=0 -> pc_we=0 in EXEC.
- instr=16'h2123 (LW), mem_ack low 3 cycles in MEM -> mem_req held 4 cycles with mem_addr_sel=1, mem_we=0; WB has wb_sel=1.
- MEM_TIMEOUT=4, mem_ack never asserted in FETCH -> halted=1 and error=2 after 4 FETCH cycles; start pulses ignored; rst_n low clears error.
- Variants:
  - instr=16'h7000 -> error=1, halted=1 after DECODE.
  - instr=16'hF000 -> halted=1, error=0.
  - mem_ack on the last timeout cycle -> no error.
- Assert rst_n low while in MEM with mem_req=1 -> mem_req=0 the same cycle, offset_sel=NONE, state IDLE until start.
